// File: rtl/jt51_wrq_pkg.sv
// jt51_wrq_pkg: shared entry layout and issue FSM encoding for the CPU write queue.
package jt51_wrq_pkg;
    localparam int WRQ_W = 9;
    typedef struct packed {
        logic       a0;
        logic [7:0] d;
    } wrq_entry_t;
    typedef enum logic { IDLE = 1'b0, HOLD = 1'b1 } wrq_state_t;
    function automatic wrq_entry_t wrq_pack(input logic a0, input logic [7:0] d);
        return wrq_entry_t'({a0, d});
    endfunction
endpackage

// File: rtl/jt51_wrq_if.sv
// jt51_wrq_if: register write bus ({write,a0,din} plus busy back-pressure).
interface jt51_wrq_if;
    logic       write;
    logic       a0;
    logic [7:0] din;
    logic       busy;
    modport master(output write, a0, din, input busy);
    modport slave(input write, a0, din, output busy);
endinterface

// File: rtl/jt51_wrq_mem.sv
// jt51_wrq_mem: 2**AW x 9 simple dual-port RAM, async read, sync write, storage not reset.
module jt51_wrq_mem
    import jt51_wrq_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  wrq_entry_t    wd,
    input  logic [AW-1:0] ra,
    output wrq_entry_t    rd
);
    logic [WRQ_W-1:0] mem [2**AW];
    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;
    assign rd = wrq_entry_t'(mem[ra]);
endmodule

// File: rtl/jt51_wrq.sv
// jt51_wrq: CPU write queue replaying {a0,din} writes to jt51_mmr, paced by cen and busy.
module jt51_wrq
    import jt51_wrq_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          ovf_clr,
    jt51_wrq_if.slave     cpu,
    jt51_wrq_if.master    mmr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    wrq_entry_t    head;
    wrq_state_t    state, state_nx;
    logic          seen, cen_one, push, issue, busy_done, timeout;
    assign full  = level[AW];
    assign empty = level == '0;
    assign push  = cpu.write & ~full;
    // Strobe is gated with cen so it always lands on the MMR's enabled clock
    assign issue = state == IDLE & ~empty & cen & (~head.a0 | ~mmr.busy);
    assign cpu.busy  = full;
    assign mmr.write = issue;
    assign mmr.a0    = ~empty & head.a0;
    assign mmr.din   = empty ? 8'd0 : head.d;
    assign busy_done = seen & ~mmr.busy;
    assign timeout   = ~seen & ~mmr.busy & cen & cen_one;
    jt51_wrq_mem #(.AW(AW)) u_mem (
        .clk (clk),
        .we  (push),
        .wa  (wr_ptr),
        .wd  (wrq_pack(cpu.a0, cpu.din)),
        .ra  (rd_ptr),
        .rd  (head)
    );
    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = (issue & head.a0) ? HOLD : IDLE;
        else
            state_nx = (busy_done | timeout) ? IDLE : HOLD;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf     <= 1'b0;
            state   <= IDLE;
            seen    <= 1'b0;
            cen_one <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(issue);
            level   <= level + (AW+1)'(push) - (AW+1)'(issue);
            ovf     <= (cpu.write & full) | (ovf & ~ovf_clr);
            state   <= state_nx;
            // Busy-seen and timeout tracking restart on every entry into HOLD
            seen    <= state == HOLD & (seen | mmr.busy);
            cen_one <= state == HOLD & (cen_one | cen);
        end
    end
endmodule

// File: tb/tb_jt51_wrq.sv
// tb_jt51_wrq: directed stimulus with a scoreboard queue checked by a strobe monitor.
module tb_jt51_wrq;
    localparam int AW = 4;
    logic clk = 0, rst_n = 0, cen = 0, ovf_clr = 0, force_busy = 0;
    logic full, empty, ovf;
    logic [AW:0] level;
    int checks = 0, failures = 0, strobes = 0, s0 = 0;
    int cen_div = 1, cen_phase = 0, busy_cnt = 0;
    longint cen_seen = 0, last_data = -1;
    logic [8:0] exp_q [$];

    jt51_wrq_if cpu();
    jt51_wrq_if mmr();

    jt51_wrq #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .ovf_clr(ovf_clr),
        .cpu(cpu), .mmr(mmr),
        .full(full), .empty(empty), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        cen_phase = (cen_phase + 1 >= cen_div) ? 0 : cen_phase + 1;
        cen = (cen_phase == 0);
    end

    // MMR model: busy for 32 cen pulses after a data write is taken on a cen edge
    always @(posedge clk or negedge rst_n)
        if (!rst_n) busy_cnt <= 0;
        else if (cen && mmr.write && mmr.a0) busy_cnt <= 32;
        else if (cen && busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    assign mmr.busy = force_busy | (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mmr.write) begin
            strobes++;
            chk("strobe_on_cen", cen, 1);
            chk("data_strobe_while_busy", mmr.a0 & mmr.busy, 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual=%h required=none", {mmr.a0, mmr.din});
            end else
                chk("strobe_entry", {mmr.a0, mmr.din}, exp_q.pop_front());
            if (mmr.a0) begin
                if (last_data >= 0) chk("data_spacing_ge33", (cen_seen - last_data) >= 33, 1);
                last_data = cen_seen;
            end
        end
        if (cen) cen_seen++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic a0, input logic [7:0] d, input bit acc);
        cpu.write = 1;
        cpu.a0 = a0;
        cpu.din = d;
        if (acc) exp_q.push_back({a0, d});
        idle(1);
        cpu.write = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            idle(1);
            k++;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        cpu.write = 0;
        cpu.a0 = 0;
        cpu.din = 0;
        idle(3);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_write", mmr.write, 0);
        chk("rst_a0", mmr.a0, 0);
        chk("rst_din", mmr.din, 0);
        rst_n = 1;
        idle(2);

        cen_div = 4; last_data = -1; s0 = strobes;
        wr(0, 8'h20, 1);
        wr(1, 8'hC7, 1);
        drain("t1_drain", 200);
        idle(2);
        chk("t1_strobes", strobes - s0, 2);
        chk("t1_level", level, 0);
        chk("t1_empty", empty, 1);
        idle(140);

        cen_div = 1; last_data = -1; s0 = strobes;
        for (int i = 0; i < 8; i++) wr(1, 8'(i), 1);
        drain("t2_drain", 400);
        chk("t2_strobes", strobes - s0, 8);
        idle(40);

        force_busy = 1; s0 = strobes;
        for (int i = 0; i < 17; i++) wr(1, 8'(8'h40 + i), i < 16);
        chk("t3_level", level, 16);
        chk("t3_full", full, 1);
        chk("t3_ovf", ovf, 1);
        chk("t3_no_strobe_busy", strobes - s0, 0);
        ovf_clr = 1;
        idle(1);
        ovf_clr = 0;
        chk("t3_ovf_clr", ovf, 0);

        ovf_clr = 1;
        wr(1, 8'h99, 0);
        ovf_clr = 0;
        chk("t4_set_wins", ovf, 1);
        ovf_clr = 1;
        idle(1);
        ovf_clr = 0;
        chk("t4_ovf_clr2", ovf, 0);
        force_busy = 0; last_data = -1;
        wr(1, 8'h9A, 0);
        chk("t4_full_pop_level", level, 15);
        chk("t4_full_pop_ovf", ovf, 1);
        drain("t4_drain16", 700);
        idle(40);
        force_busy = 1;
        wr(1, 8'hA1, 1);
        wr(1, 8'hA2, 1);
        chk("t4_level2", level, 2);
        force_busy = 0; last_data = -1;
        wr(0, 8'hA3, 1);
        chk("t4_pushpop_level", level, 2);
        drain("t4_drain3", 120);
        idle(40);

        cen_div = 4; force_busy = 1; s0 = strobes;
        wr(0, 8'h55, 1);
        drain("t5_addr_busy", 10);
        chk("t5_strobes", strobes - s0, 1);
        force_busy = 0;
        idle(8);

        cen_div = 1; last_data = -1;
        idle(4);
        wr(1, 8'hD0, 1);
        wr(1, 8'hD1, 0);
        wr(1, 8'hD2, 0);
        wr(1, 8'hD3, 0);
        chk("t6_level3", level, 3);
        rst_n = 0;
        #1;
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_write", mmr.write, 0);
        chk("t6_rst_full", full, 0);
        idle(1);
        rst_n = 1;
        s0 = strobes;
        idle(100);
        chk("t6_no_strobes", strobes - s0, 0);
        chk("t6_empty", empty, 1);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
